// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the serial BCD add/sub unit.
// Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_NINE = 4'd9;
    localparam digit_t BCD_SIX  = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_cell.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_cell
// Description : One-digit BCD adder with carry-in, optional nine's complement
//               of y and +6 decimal correction (combinational).
// Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       comp,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    digit_t     w_y;
    logic [4:0] w_sum;

    always_comb begin
        w_y   = comp ? digit_t'(BCD_NINE - y) : y;
        w_sum = 5'(x) + 5'(w_y) + 5'(cin);
        if (w_sum > 5'(BCD_NINE)) begin
            digit = 4'(w_sum + 5'(BCD_SIX));
            cout  = 1'b1;
        end else begin
            digit = w_sum[3:0];
            cout  = 1'b0;
        end
    end

endmodule : bcd_digit_cell
`default_nettype wire

// File: rtl/bcd_addsub_serial.sv
`default_nettype none
// ============================================================================
// Module      : bcd_addsub_serial
// Description : Digit-serial packed-BCD adder/subtractor, LSD first, with a
//               ten's-complement pass for negative differences.
// Revision    : 1.0  initial release
// ============================================================================
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sub,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    output logic [4*NDIG-1:0] result,
    output logic              cout,
    output logic              neg,
    output logic              err,
    output logic              busy,
    output logic              done
);

    localparam int             IW     = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0]  c_last = IW'(NDIG - 1);

    state_t                  r_state, w_next;
    logic [NDIG-1:0][3:0]    r_a, r_b, r_result;
    logic                    r_sub, r_carry, r_cout, r_neg, r_err;
    logic [IW-1:0]           r_idx;

    logic                    w_in_err;
    logic [3:0]              w_x, w_y, w_digit;
    logic                    w_comp, w_cout;

    always_comb begin
        w_in_err = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (a[4*i +: 4] > BCD_NINE || b[4*i +: 4] > BCD_NINE) begin
                w_in_err = 1'b1;
            end
        end
    end

    // FIX reuses the cell as 0 + (9 - r) + carry, i.e. ten's complement.
    always_comb begin
        w_x    = r_a[r_idx];
        w_y    = r_b[r_idx];
        w_comp = r_sub;
        if (r_state == FIX) begin
            w_x    = '0;
            w_y    = r_result[r_idx];
            w_comp = 1'b1;
        end
    end

    bcd_digit_cell u_cell (
        .x     (w_x),
        .y     (w_y),
        .comp  (w_comp),
        .cin   (r_carry),
        .digit (w_digit),
        .cout  (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (r_idx == c_last) w_next = (r_sub && !w_cout) ? FIX : DONE;
            FIX:     if (r_idx == c_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a      <= a;
                    r_b      <= b;
                    r_sub    <= sub;
                    r_carry  <= sub;
                    r_err    <= w_in_err;
                    r_idx    <= '0;
                    r_result <= '0;
                    r_cout   <= 1'b0;
                    r_neg    <= 1'b0;
                end
                RUN: begin
                    r_result[r_idx] <= w_digit;
                    r_carry         <= w_cout;
                    r_idx           <= r_idx + 1'b1;
                    if (r_idx == c_last) begin
                        r_idx <= '0;
                        if (!r_sub) begin
                            r_cout <= w_cout & ~r_err;
                        end else if (!w_cout) begin
                            // No end-around carry: difference is negative.
                            r_neg   <= 1'b1;
                            r_carry <= 1'b1;
                        end
                        if (r_err && !(r_sub && !w_cout)) begin
                            r_result <= '0;
                        end
                    end
                end
                FIX: begin
                    r_result[r_idx] <= w_digit;
                    r_carry         <= w_cout;
                    r_idx           <= r_idx + 1'b1;
                    if (r_idx == c_last) begin
                        r_idx <= '0;
                        if (r_err) begin
                            r_result <= '0;
                            r_neg    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign neg    = r_neg;
    assign err    = r_err;
    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);

endmodule : bcd_addsub_serial
`default_nettype wire

// File: tb/tb_bcd_addsub_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_addsub_serial
// Description : Scoreboard bench for bcd_addsub_serial with an integer model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_addsub_serial;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, sub;
    logic [W-1:0] a, b;
    logic [W-1:0] result;
    logic         cout, neg, err, busy, done;

    typedef struct {
        logic [W-1:0] result;
        logic         cout;
        logic         neg;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;

    bcd_addsub_serial #(.NDIG(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .result (result),
        .cout   (cout),
        .neg    (neg),
        .err    (err),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) n_done++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
        exp_t e;
        int   va, vb, s, lim;
        bit   bad = 0;
        lim = 1;
        for (int i = 0; i < N; i++) begin
            lim = lim * 10;
            if (ta[4*i +: 4] > 4'd9 || tb_v[4*i +: 4] > 4'd9) bad = 1;
        end
        e.result = '0; e.cout = 0; e.neg = 0; e.err = bad; e.lat = N + 1;
        if (!bad) begin
            va = bcd2int(ta);
            vb = bcd2int(tb_v);
            if (!ts) begin
                s        = va + vb;
                e.cout   = (s >= lim);
                e.result = int2bcd(s % lim);
            end else if (va >= vb) begin
                e.result = int2bcd(va - vb);
            end else begin
                e.result = int2bcd(vb - va);
                e.neg    = 1;
                e.lat    = 2 * N + 1;
            end
        end
        return e;
    endfunction

    // mode 0: plain, 1: re-pulse start during RUN, 2: start held in the DONE cycle
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts, input int mode);
        exp_t e;
        int   lat, d0;
        d0 = n_done;
        sb.push_back(model(ta, tb_v, ts));
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; sub = ts;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); sub = ~ts;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (mode == 1 && lat == 2) start = 1'b1;
            if (mode == 1 && lat == 3) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        if (done !== 1'b1) begin
            check_eq("done_timeout", 64'(lat), 64'(e.lat));
        end else begin
            check_eq("latency", 64'(lat), 64'(e.lat));
            check_eq("result",  64'(result), 64'(e.result));
            check_eq("cout",    64'(cout), 64'(e.cout));
            check_eq("neg",     64'(neg), 64'(e.neg));
            check_eq("err",     64'(err), 64'(e.err));
        end
        if (mode == 2) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("done_pulse", 64'(done), 64'(0));
        repeat (10) @(negedge clk);
        check_eq("idle_busy", 64'(busy), 64'(0));
        check_eq("hold_result", 64'(result), 64'(e.result));
        check_eq("done_count", 64'(n_done - d0), 64'(1));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_outs", {result, cout, neg, err, busy, done}, '0);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h5678, 1'b0, 0);
        run_op(16'h9999, 16'h0001, 1'b0, 0);
        run_op(16'h5000, 16'h1234, 1'b1, 0);
        run_op(16'h0123, 16'h0456, 1'b1, 0);
        run_op(16'h0042, 16'h0042, 1'b1, 0);
        run_op(16'h00A0, 16'h0000, 1'b0, 0);
        run_op(16'h0500, 16'h0500, 1'b0, 1);
        run_op(16'h0007, 16'h9000, 1'b1, 2);

        for (int k = 0; k < 8; k++) begin
            logic [W-1:0] ra, rb;
            for (int i = 0; i < N; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        // Abort a negative subtraction in the middle of its FIX pass.
        begin
            int d0;
            d0 = n_done;
            @(negedge clk);
            start = 1'b1; a = 16'h0123; b = 16'h0456; sub = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (5) @(negedge clk);
            check_eq("busy_in_fix", 64'(busy), 64'(1));
            #2 rst_n = 1'b0;
            #1 check_eq("async_rst", {result, cout, neg, err, busy, done}, '0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (15) @(negedge clk);
            check_eq("no_done_after_abort", 64'(n_done - d0), 64'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bcd_addsub_serial
`default_nettype wire

// File: doc/bcd_addsub_serial.md
BCD_ADDSUB_SERIAL -- requirements
Module: bcd_addsub_serial

Interface
REQ-001 Parameter NDIG, default 4: number of BCD digits per operand; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 sub  input  1  0 = a+b, 1 = a-b; captured with start.
REQ-006 a  input  4*NDIG  minuend/addend, packed BCD, digit 0 in bits [3:0].
REQ-007 b  input  4*NDIG  subtrahend/addend, packed BCD.
REQ-008 result  output  4*NDIG  packed BCD magnitude of the result.
REQ-009 cout  output  1  add overflow (decimal carry out of MSD); 0 for sub.
REQ-010 neg  output  1  sub result negative (a<b); 0 for add.
REQ-011 err  output  1  some operand digit >9.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse; result/cout/neg/err valid from that cycle until next start.

Function
REQ-014 States: IDLE, RUN, FIX, DONE; held in one registered state variable.
REQ-015 IDLE: start=1 -> capture a, b, sub into registers, digit index=0, carry=sub, err=OR of (digit>9) over all captured digits; go RUN.
REQ-016 RUN: one digit per cycle, LSD first: sum = a_i + (sub ? 9-b_i : b_i) + carry; if sum>9 then digit=sum+6 mod 16, carry=1, else digit=sum, carry=0; digit written into result slot i.
REQ-017 RUN exits after digit NDIG-1: add -> DONE with cout=final carry; sub with carry=1 -> DONE with neg=0; sub with carry=0 -> FIX with neg=1.
REQ-018 FIX: NDIG cycles, LSD first, result_i = (9-result_i) + carry with decimal correction, initial carry=1 (ten's complement); then DONE.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE.
REQ-020 Latency start-edge to done-high: NDIG+1 cycles (add, non-negative sub), 2*NDIG+1 cycles (negative sub).
REQ-021 start while busy=1 ignored; operands changing while busy have no effect.
REQ-022 err=1: arithmetic still runs with identical timing; result forced to all zero, cout=0, neg=0 at DONE.
REQ-023 Zero difference (a=b, sub=1): result=0, neg=0.
REQ-024 start asserted in the DONE cycle is ignored; back-to-back operation requires start in IDLE.
REQ-025 result, cout, neg, err hold their values in IDLE until the next accepted start clears them to 0.

Reset
REQ-026 rst_n low asynchronously forces state=IDLE, result=0, cout=0, neg=0, err=0, busy=0, done=0, index=0, carry=0.
REQ-027 Reset mid-RUN or mid-FIX aborts the operation; no done pulse for it.

Structure
REQ-028 Package bcd_pkg holds the state enum, the 4-bit digit type, and constants BCD_NINE=9 and BCD_SIX=6.
REQ-029 One sub-module, bcd_digit_cell: combinational one-digit add with carry-in, optional nine's-complement of operand b, and +6 correction; instantiated once and shared by RUN and FIX.

Verification (NDIG=4)
REQ-030 Add 1234+5678 -> result 6912, cout 0, done 5 cycles after start.
REQ-031 Add 9999+0001 -> result 0000, cout 1.
REQ-032 Sub 5000-1234 -> result 3766, neg 0, latency 5 cycles.
REQ-033 Sub 0123-0456 -> result 0333, neg 1, latency 9 cycles; sub 0042-0042 -> result 0000, neg 0.
REQ-034 a=0x00A0, add -> err 1, result 0000, done at 5 cycles.
REQ-035 start re-pulsed during RUN -> ignored, single done. rst_n low during FIX -> all outputs 0 immediately; no done.
